sel_stream_demux4: RTL and testbench

- 1-to-4 stream demultiplexer: routes each 8-bit input word to one of four output channels by a 2-bit select code.
- Inverse of the 4:1 select-code data mux used on the gather side; select code 2'b00→ch0, 01→ch1, 10→ch2, 11→ch3.
- Each channel has a small FIFO with valid/ready handshakes on both sides, so a stalled consumer blocks only its own channel.
- Each channel also has a saturating accept counter for debug.

---
 rtl/sel_stream_demux4.sv | 113 +++++++++++
 tb/tb_sel_stream_demux4.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_stream_demux4.sv
// sel_stream_demux4: 1-to-4 stream demultiplexer.
// Each input word is routed to one of four channel FIFOs by a 2-bit select code
// (00->ch0, 01->ch1, 10->ch2, 11->ch3). Every channel has its own small FIFO, so a
// stalled consumer blocks only its own channel. Each channel also has a saturating
// accept counter for debug.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clock edge where valid and ready are both high.
//   A valid source holds its payload (and, on the input side, in_sel) stable
//   until the transfer. in_ready = !full[in_sel]. It depends only on in_sel and the
//   registered FIFO state, never on in_valid or out_ready, so there is no
//   ready->ready combinational path. A same-cycle pop on a full channel does not
//   open in_ready for that cycle. out_valid[i] is purely registered: a word pushed
//   at edge N becomes visible after edge N, with no fall-through.
module sel_stream_demux4 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [4*CNT_W-1:0]  chan_cnt,
  input  logic                clr_cnt
);

  // Index bits address the storage; one extra wrap bit separates full from empty.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [3:0] dest;      // one-hot decode of in_sel
  logic [3:0] full;      // per-channel full flag
  logic [3:0] empty;     // per-channel empty flag
  logic       push;      // input transfer this cycle
  logic [3:0] push_vec;  // channel written this cycle (at most one bit set)
  logic [3:0] pop_vec;   // channels popped this cycle (any combination)

  // Select decode and input-side handshake; every code maps to a channel.
  always_comb begin
    dest     = 4'b0001 << in_sel;
    in_ready = !full[in_sel];
    push     = in_valid && in_ready;
    push_vec = dest & {4{push}};
    pop_vec  = out_valid & out_ready;
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Full when index bits match and wrap bits differ; empty when pointers match.
    assign full[g]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty[g] = (wr_ptr_q == rd_ptr_q);

    // Head of the FIFO straight from storage; meaningless while the channel is empty.
    assign out_valid[g]                   = !empty[g];
    assign out_data[g*DATA_W +: DATA_W]   = mem_q[rd_ptr_q[AW-1:0]];
    assign chan_cnt[g*CNT_W +: CNT_W]     = cnt_q;

    // Next-state pointers and counter; clear wins over a same-cycle increment,
    // and the counter sticks at all-ones instead of wrapping.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_vec[g]) begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_vec[g]) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (clr_cnt) begin
        cnt_d = '0;
      end else if (push_vec[g] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    // Pointer and counter registers; reset empties the channel immediately.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage write; cleared on reset so out_data reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[k] <= '0;
        end
      end else if (push_vec[g]) begin
        mem_q[wr_ptr_q[AW-1:0]] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_sel_stream_demux4.sv
// Directed bench for sel_stream_demux4 with 4-bit accept counters.
module tb_sel_stream_demux4;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
  logic [4*CNT_W-1:0]  chan_cnt;
  logic                clr_cnt;

  int checks;
  int failures;

  sel_stream_demux4 #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .chan_cnt (chan_cnt),
    .clr_cnt  (clr_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        clr;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[18];

  // Driver tasks
  task automatic drive(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                       input logic [3:0] ordy, input logic clr);
    in_valid  = vld;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
    clr_cnt   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ch(input string name, input int ch, input logic [7:0] exp);
    chk(name, {24'h0, out_data[ch*DATA_W +: DATA_W]}, {24'h0, exp});
  endtask

  initial begin
    logic [31:0] od_exp;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    drive(0, 2'd0, 8'h00, 4'h0, 0);

    // Table: per cycle, inputs applied then outputs checked before the edge.
    // Basic route, clear, round-robin, then ch1 fill/stall and ordered drain.
    vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'hF, 1'b0, 1'b1, 4'h0, 32'h00000000, 16'h0000};
    vecs[1]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'h4, 32'h00A50000, 16'h0100};
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 1'b1, 4'h0, 32'h00000000, 16'h0100};
    vecs[3]  = '{1'b1, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'h0, 32'h00000000, 16'h0000};
    vecs[4]  = '{1'b1, 2'd1, 8'h01, 4'hF, 1'b0, 1'b1, 4'h1, 32'h00000000, 16'h0001};
    vecs[5]  = '{1'b1, 2'd2, 8'h02, 4'hF, 1'b0, 1'b1, 4'h2, 32'h00000100, 16'h0011};
    vecs[6]  = '{1'b1, 2'd3, 8'h03, 4'hF, 1'b0, 1'b1, 4'h4, 32'h00020000, 16'h0111};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'h8, 32'h03000000, 16'h1111};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'h0, 32'h00000000, 16'h1111};
    vecs[9]  = '{1'b1, 2'd1, 8'h11, 4'h0, 1'b0, 1'b1, 4'h0, 32'h00000000, 16'h1111};
    vecs[10] = '{1'b1, 2'd1, 8'h22, 4'h0, 1'b0, 1'b1, 4'h2, 32'h00001100, 16'h1121};
    vecs[11] = '{1'b1, 2'd1, 8'h33, 4'h0, 1'b0, 1'b0, 4'h2, 32'h00001100, 16'h1131};
    vecs[12] = '{1'b1, 2'd3, 8'h44, 4'h0, 1'b0, 1'b1, 4'h2, 32'h00001100, 16'h1131};
    vecs[13] = '{1'b1, 2'd1, 8'h33, 4'h2, 1'b0, 1'b0, 4'hA, 32'h44001100, 16'h2131};
    vecs[14] = '{1'b1, 2'd1, 8'h33, 4'h2, 1'b0, 1'b1, 4'hA, 32'h44002200, 16'h2131};
    vecs[15] = '{1'b0, 2'd1, 8'h00, 4'h2, 1'b0, 1'b1, 4'hA, 32'h44003300, 16'h2141};
    vecs[16] = '{1'b0, 2'd1, 8'h00, 4'h8, 1'b0, 1'b1, 4'h8, 32'h44000000, 16'h2141};
    vecs[17] = '{1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b1, 4'h0, 32'h00000000, 16'h2141};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {28'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_chan_cnt", {16'h0, chan_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].vld, vecs[v].sel, vecs[v].data, vecs[v].ordy, vecs[v].clr);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", v), {31'h0, in_ready}, {31'h0, vecs[v].exp_rdy});
      chk($sformatf("v%0d_out_valid", v), {28'h0, out_valid}, {28'h0, vecs[v].exp_ov});
      od_exp = vecs[v].exp_od;
      for (int c = 0; c < 4; c++) begin
        if (vecs[v].exp_ov[c]) begin
          chk_ch($sformatf("v%0d_data_ch%0d", v, c), c, od_exp[c*8 +: 8]);
        end
      end
      chk($sformatf("v%0d_chan_cnt", v), {16'h0, chan_cnt}, {16'h0, vecs[v].exp_cnt});
      tick();
    end

    // Full ch0 with consumer ready in the same cycle: no bypass.
    // The first push also carries clr_cnt, which must win over the increment.
    drive(1, 2'd0, 8'hC1, 4'h0, 1);
    @(negedge clk);
    chk("t4_rdy_first", {31'h0, in_ready}, 32'h1);
    tick();
    drive(1, 2'd0, 8'hC2, 4'h0, 0);
    @(negedge clk);
    chk("t4_clr_priority", {16'h0, chan_cnt}, 32'h0);
    chk("t4_rdy_second", {31'h0, in_ready}, 32'h1);
    tick();
    drive(1, 2'd0, 8'hC3, 4'h1, 0);
    @(negedge clk);
    chk("t4_no_bypass", {31'h0, in_ready}, 32'h0);
    chk("t4_ov_full", {28'h0, out_valid}, 32'h1);
    chk_ch("t4_head_c1", 0, 8'hC1);
    tick();
    @(negedge clk);
    chk("t4_rdy_after_pop", {31'h0, in_ready}, 32'h1);
    chk_ch("t4_head_c2", 0, 8'hC2);
    tick();
    drive(0, 2'd0, 8'h00, 4'h1, 0);
    @(negedge clk);
    chk("t4_ov_c3", {28'h0, out_valid}, 32'h1);
    chk_ch("t4_head_c3", 0, 8'hC3);
    chk("t4_cnt", {16'h0, chan_cnt}, 32'h0002);
    tick();
    @(negedge clk);
    chk("t4_drained", {28'h0, out_valid}, 32'h0);

    // Saturation: 20 accepted words to ch3, 4-bit counter stops at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'd3, 8'(i), 4'h8, 0);
      @(negedge clk);
      chk($sformatf("t5_rdy_%0d", i), {31'h0, in_ready}, 32'h1);
      tick();
    end
    drive(0, 2'd0, 8'h00, 4'h8, 0);
    @(negedge clk);
    chk("t5_saturated", {16'h0, chan_cnt}, 32'h0000F002);
    tick();
    drive(1, 2'd3, 8'hEE, 4'h8, 1);
    @(negedge clk);
    tick();
    drive(0, 2'd0, 8'h00, 4'h8, 0);
    @(negedge clk);
    chk("t5_clr_during_push", {16'h0, chan_cnt}, 32'h0);
    chk("t5_ov_ee", {28'h0, out_valid}, 32'h8);
    chk_ch("t5_head_ee", 3, 8'hEE);
    tick();

    // Reset in the middle of buffered traffic.
    drive(1, 2'd2, 8'hB1, 4'h0, 0);
    tick();
    drive(1, 2'd2, 8'hB2, 4'h0, 0);
    tick();
    drive(0, 2'd2, 8'h00, 4'h0, 0);
    @(negedge clk);
    chk("t6_buffered_ov", {28'h0, out_valid}, 32'h4);
    chk("t6_buffered_cnt", {16'h0, chan_cnt}, 32'h0200);
    chk("t6_full_rdy", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    #1;
    chk("t6_async_ov", {28'h0, out_valid}, 32'h0);
    chk("t6_async_cnt", {16'h0, chan_cnt}, 32'h0);
    chk("t6_async_rdy", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 2'd2, 8'h5A, 4'h0, 0);
    @(negedge clk);
    chk("t6_post_ov0", {28'h0, out_valid}, 32'h0);
    tick();
    drive(0, 2'd0, 8'h00, 4'h4, 0);
    @(negedge clk);
    chk("t6_post_ov", {28'h0, out_valid}, 32'h4);
    chk_ch("t6_first_5a", 2, 8'h5A);
    chk("t6_post_cnt", {16'h0, chan_cnt}, 32'h0100);
    tick();
    drive(0, 2'd0, 8'h00, 4'h0, 0);
    @(negedge clk);
    chk("t6_final_empty", {28'h0, out_valid}, 32'h0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
